// File: rtl/conv_result_writer.sv
// rtl/conv_result_writer.sv - requantizes accumulator results and writes them row-major to the output feature map
module conv_result_writer #(
  parameter int DATA_IN_W  = 32,
  parameter int DATA_OUT_W = 8,
  parameter int N_ROW      = 26,
  parameter int N_COL      = 26,
  parameter int ADDR_W     = 10,
  parameter int SHIFT_W    = 5,
  parameter int RELU       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SHIFT_W-1:0]    shift,
  input  logic                  in_valid,
  input  logic [DATA_IN_W-1:0]  in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_OUT_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0]     row,
  output logic [ADDR_W-1:0]     col,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_ROW - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(N_COL - 1);
  localparam logic signed [DATA_IN_W-1:0] SAT_MAX = DATA_IN_W'((1 << (DATA_OUT_W - 1)) - 1);
  localparam logic signed [DATA_IN_W-1:0] SAT_MIN = DATA_IN_W'(-(1 << (DATA_OUT_W - 1)));

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_OUT_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0]       row_q, row_d;
  logic [ADDR_W-1:0]       col_q, col_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [SHIFT_W-1:0]      shift_q, shift_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    xfer;
  logic signed [DATA_IN_W-1:0] shifted;
  logic signed [DATA_IN_W-1:0] clipped;
  logic [DATA_OUT_W-1:0]   quant;

  assign xfer = in_valid && in_ready_q && (state_q == S_RUN);

  // Requantize the incoming result: arithmetic shift, optional ReLU, then saturate to the output range
  always_comb begin
    shifted = $signed(in_data) >>> shift_q;
    clipped = shifted;
    if ((RELU != 0) && (shifted < 0)) begin
      clipped = '0;
    end
    if (clipped > SAT_MAX) begin
      clipped = SAT_MAX;
    end else if (clipped < SAT_MIN) begin
      clipped = SAT_MIN;
    end
    quant = clipped[DATA_OUT_W-1:0];
  end

  // Next-state and registered-output logic; the running address replaces a row*N_COL multiply
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    row_d       = row_q;
    col_d       = col_q;
    addr_d      = addr_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          in_ready_d = 1'b1;
          row_d      = '0;
          col_d      = '0;
          addr_d     = '0;
          shift_d    = shift;
        end
      end
      S_RUN: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = quant;
          addr_d      = addr_q + ADDR_W'(1);
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d      = '0;
              addr_d     = '0;
              state_d    = S_DONE;
              in_ready_d = 1'b0;
            end else begin
              row_d = row_q + ADDR_W'(1);
            end
          end else begin
            col_d = col_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      row_q       <= row_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign row       = row_q;
  assign col       = col_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_result_writer.sv
// tb/tb_conv_result_writer.sv - scoreboard bench for conv_result_writer (default and small RELU=0 geometry)
module tb_conv_result_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // default instance: 26x26, RELU=1
  logic        start_a = 1'b0;
  logic [4:0]  shift_a = '0;
  logic        in_valid_a = 1'b0;
  logic [31:0] in_data_a = '0;
  logic        in_ready_a, mem_we_a, busy_a, done_a;
  logic [9:0]  mem_addr_a, row_a, col_a;
  logic [7:0]  mem_wdata_a;

  // small instance: 3x4, RELU=0
  logic        start_b = 1'b0;
  logic [4:0]  shift_b = '0;
  logic        in_valid_b = 1'b0;
  logic [31:0] in_data_b = '0;
  logic        in_ready_b, mem_we_b, busy_b, done_b;
  logic [3:0]  mem_addr_b, row_b, col_b;
  logic [7:0]  mem_wdata_b;

  conv_result_writer u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .shift(shift_a),
    .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .row(row_a), .col(col_a), .busy(busy_a), .done(done_a)
  );

  conv_result_writer #(.N_ROW(3), .N_COL(4), .ADDR_W(4), .RELU(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .shift(shift_b),
    .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .row(row_b), .col(col_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    int     addr;
    int     data;
    longint due;
  } wr_t;

  wr_t sb_a[$];
  wr_t sb_b[$];
  int  addr_a = 0;
  int  addr_b = 0;
  int  done_cnt_a = 0;
  int  done_cnt_b = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // write monitors: every write must match the oldest queued expectation, one cycle after accept
  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (mem_we_a) begin
      if (sb_a.size() == 0) begin
        chk("a_unexpected_write", longint'(mem_addr_a), -1);
      end else begin
        wr_t e;
        e = sb_a.pop_front();
        chk("a_addr", longint'(mem_addr_a), e.addr);
        chk("a_data", longint'($signed(mem_wdata_a)), e.data);
        chk("a_latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (done_b) done_cnt_b++;
    if (mem_we_b) begin
      if (sb_b.size() == 0) begin
        chk("b_unexpected_write", longint'(mem_addr_b), -1);
      end else begin
        wr_t e;
        e = sb_b.pop_front();
        chk("b_addr", longint'(mem_addr_b), e.addr);
        chk("b_data", longint'($signed(mem_wdata_b)), e.data);
        chk("b_latency", cyc, e.due);
      end
    end
  end

  task automatic beat_a(input logic [31:0] d, input int exp, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      in_valid_a = 1'b0;
      in_data_a  = $urandom;
      tick();
    end
    chk("a_row", longint'(row_a), addr_a / 26);
    chk("a_col", longint'(col_a), addr_a % 26);
    chk("a_ready", longint'(in_ready_a), 1);
    in_valid_a = 1'b1;
    in_data_a  = d;
    sb_a.push_back('{addr_a, exp, cyc + 1});
    addr_a++;
    tick();
    in_valid_a = 1'b0;
  endtask

  task automatic beat_b(input logic [31:0] d, input int exp);
    chk("b_row", longint'(row_b), addr_b / 4);
    chk("b_col", longint'(col_b), addr_b % 4);
    chk("b_ready", longint'(in_ready_b), 1);
    in_valid_b = 1'b1;
    in_data_b  = d;
    sb_b.push_back('{addr_b, exp, cyc + 1});
    addr_b++;
    tick();
    in_valid_b = 1'b0;
  endtask

  task automatic start_frame_a(input int sh);
    start_a = 1'b1;
    shift_a = 5'(sh);
    tick();
    start_a = 1'b0;
    addr_a  = 0;
    chk("a_busy_run", longint'(busy_a), 1);
  endtask

  task automatic end_frame_a(input int exp_done);
    chk("a_ready_low_after_last", longint'(in_ready_a), 0);
    chk("a_busy_in_done", longint'(busy_a), 1);
    chk("a_done_early", longint'(done_a), 0);
    tick();
    chk("a_done_pulse", longint'(done_a), 1);
    chk("a_busy_idle", longint'(busy_a), 0);
    chk("a_no_write_after_last", longint'(mem_we_a), 0);
    tick();
    chk("a_done_one_cycle", longint'(done_a), 0);
    chk("a_done_count", done_cnt_a, exp_done);
    chk("a_sb_empty", sb_a.size(), 0);
  endtask

  task automatic full_frame_a(input bit gaps, input int exp_done);
    start_frame_a(0);
    for (int k = 0; k < 676; k++) begin
      beat_a(k, (k > 127) ? 127 : k,
             (gaps && ($urandom_range(0, 1) == 1)) ? int'($urandom_range(1, 3)) : 0);
    end
    end_frame_a(exp_done);
  endtask

  task automatic chk_a_all_zero(input string tag);
    chk({tag, "_in_ready"}, longint'(in_ready_a), 0);
    chk({tag, "_mem_we"}, longint'(mem_we_a), 0);
    chk({tag, "_mem_addr"}, longint'(mem_addr_a), 0);
    chk({tag, "_mem_wdata"}, longint'(mem_wdata_a), 0);
    chk({tag, "_row"}, longint'(row_a), 0);
    chk({tag, "_col"}, longint'(col_a), 0);
    chk({tag, "_busy"}, longint'(busy_a), 0);
    chk({tag, "_done"}, longint'(done_a), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_a_all_zero("rst");
    chk("rst_b_mem_we", longint'(mem_we_b), 0);
    chk("rst_b_busy", longint'(busy_b), 0);
    rst = 1'b0;
    tick();

    // in_valid in IDLE is ignored
    in_valid_a = 1'b1;
    in_data_a  = 32'd5;
    tick();
    in_valid_a = 1'b0;
    chk("idle_no_write", longint'(mem_we_a), 0);
    chk("idle_not_ready", longint'(in_ready_a), 0);

    // full frame back-to-back, then with random gaps
    full_frame_a(1'b0, 1);
    full_frame_a(1'b1, 2);

    // requantization with shift=4, start during RUN, shift change mid-frame, reset mid-frame
    start_frame_a(4);
    beat_a(32'h0000_0800, 127, 0);
    beat_a(32'h0000_0150, 21, 0);
    beat_a(-32, 0, 0);
    beat_a(32'h8000_0000, 0, 0);
    shift_a = 5'd0;
    for (int k = 4; k < 300; k++) begin
      if (k == 10) begin
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("restart_row_kept", longint'(row_a), 0);
        chk("restart_col_kept", longint'(col_a), 10);
        chk("restart_busy", longint'(busy_a), 1);
      end
      beat_a(32'h0000_0150, 21, 0);
    end
    tick();
    chk("pre_rst_no_write", longint'(mem_we_a), 0);
    chk("pre_rst_sb_empty", sb_a.size(), 0);
    rst = 1'b1;
    #1;
    chk_a_all_zero("midrst");
    in_valid_a = 1'b1;
    tick();
    tick();
    chk("in_rst_no_write", longint'(mem_we_a), 0);
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_not_ready", longint'(in_ready_a), 0);
    chk("post_rst_no_write", longint'(mem_we_a), 0);
    chk("post_rst_busy", longint'(busy_a), 0);
    in_valid_a = 1'b0;
    full_frame_a(1'b0, 3);

    // small geometry with RELU=0
    start_b = 1'b1;
    shift_b = 5'd4;
    tick();
    start_b = 1'b0;
    addr_b  = 0;
    beat_b(32'h0000_0800, 127);
    beat_b(32'h0000_0150, 21);
    beat_b(-32, -2);
    beat_b(32'h8000_0000, -128);
    for (int k = 4; k < 12; k++) begin
      beat_b(k * 16, k);
    end
    chk("b_ready_low_after_last", longint'(in_ready_b), 0);
    in_valid_b = 1'b1;
    in_data_b  = 32'd99;
    tick();
    chk("b_done_pulse", longint'(done_b), 1);
    chk("b_13th_no_write", longint'(mem_we_b), 0);
    tick();
    in_valid_b = 1'b0;
    chk("b_done_one_cycle", longint'(done_b), 0);
    chk("b_idle_no_write", longint'(mem_we_b), 0);
    chk("b_done_count", done_cnt_b, 1);
    chk("b_sb_empty", sb_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
